// File: rtl/sar_adc_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation ADC controller.
package sar_adc_ctrl_pkg;

  localparam int unsigned DefNbits = 12;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSample  = 2'd1,
    StConvert = 2'd2,
    StDone    = 2'd3
  } sar_state_e;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Sequencer/analog-front-end side signals of the SAR ADC controller.
interface sar_adc_ctrl_if #(
  parameter int unsigned NBITS = 12
) ();

  logic             soc;
  logic             comp_in;
  logic             sample;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             eoc;
  logic [NBITS-1:0] data_out;
  logic             ovr;

  modport master (
    output soc, comp_in,
    input  sample, dac_code, busy, eoc, data_out, ovr
  );

  modport slave (
    input  soc, comp_in,
    output sample, dac_code, busy, eoc, data_out, ovr
  );

endinterface

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample/hold strobe, then MSB-first binary search of the DAC code
// against an external comparator, result returned with a one-cycle eoc pulse.
module sar_adc_ctrl
  import sar_adc_ctrl_pkg::*;
#(
  parameter int unsigned NBITS         = DefNbits,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sar_adc_ctrl_if.slave  bus
);

  localparam int unsigned CntMax = (SAMPLE_CYCLES - 1 > SETTLE_CYCLES) ? SAMPLE_CYCLES - 1
                                                                        : SETTLE_CYCLES;
  localparam int unsigned CntW   = cnt_width(CntMax);
  localparam int unsigned BitW   = (NBITS > 1) ? $clog2(NBITS) : 1;

  sar_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] trial;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             eoc_q, eoc_d;
  logic             ovr_q, ovr_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      eoc_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      eoc_q    <= eoc_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.soc) state_d = StSample;
      StSample:  if (cnt_zero) state_d = StConvert;
      StConvert: if (cnt_zero && (bit_q == '0)) state_d = StDone;
      StDone:    state_d = bus.soc ? StSample : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    data_d   = data_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    eoc_d    = 1'b0;
    ovr_d    = bus.soc && ((state_q == StSample) || (state_q == StConvert));
    // Current trial code with the bit under test resolved by the comparator.
    trial    = code_q;
    if (!bus.comp_in) trial[bit_q] = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.soc) begin
          code_d   = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = CntW'(SAMPLE_CYCLES - 1);
        end
      end
      StSample: begin
        if (cnt_zero) begin
          sample_d           = 1'b0;
          code_d             = '0;
          code_d[NBITS-1]    = 1'b1;
          bit_d              = BitW'(NBITS - 1);
          cnt_d              = CntW'(SETTLE_CYCLES);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StConvert: begin
        if (cnt_zero) begin
          code_d = trial;
          if (bit_q == '0) begin
            data_d = trial;
            eoc_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            code_d[bit_q - 1'b1] = 1'b1;
            bit_d                = bit_q - 1'b1;
            cnt_d                = CntW'(SETTLE_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.sample   = sample_q;
  assign bus.dac_code = code_q;
  assign bus.busy     = busy_q;
  assign bus.eoc      = eoc_q;
  assign bus.data_out = data_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Closed-loop bench: integer DAC/comparator model, result scoreboard, latency and corner checks.
module tb_sar_adc_ctrl;
  import sar_adc_ctrl_pkg::*;

  localparam int unsigned NB     = 12;
  localparam longint      VrefUv = 64'd3300000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.NBITS(NB)) a_if ();
  sar_adc_ctrl_if #(.NBITS(NB)) b_if ();

  sar_adc_ctrl #(.NBITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  sar_adc_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  longint vin_a = 0;
  longint vin_b = 0;
  // Vin >= Vref * code / 4096, in microvolts to stay exact.
  assign a_if.comp_in = (vin_a * 4096 >= VrefUv * longint'(a_if.dac_code));
  assign b_if.comp_in = (vin_b * 4096 >= VrefUv * longint'(b_if.dac_code));

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  logic [NB-1:0] exp_a_q[$];
  logic [NB-1:0] exp_b_q[$];

  typedef struct {
    longint        vin_uv;
    logic [NB-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_if.ovr) ovr_cnt_a++;
    if (b_if.ovr) ovr_cnt_b++;
    if (a_if.eoc) begin
      if (exp_a_q.size() == 0) check("eoc_a_unexpected", 1, 0);
      else check("data_a", a_if.data_out, exp_a_q.pop_front());
    end
    if (b_if.eoc) begin
      if (exp_b_q.size() == 0) check("eoc_b_unexpected", 1, 0);
      else check("data_b", b_if.data_out, exp_b_q.pop_front());
    end
  end

  task automatic set_soc(input bit sel, input logic v);
    if (sel) b_if.soc = v;
    else a_if.soc = v;
  endtask

  function automatic logic get_eoc(input bit sel);
    return sel ? b_if.eoc : a_if.eoc;
  endfunction

  // Called #1 after a posedge; counts posedges until eoc is seen.
  task automatic wait_eoc(input bit sel, input int start, input int lat, input string name);
    int cyc;
    cyc = start;
    while (!get_eoc(sel) && cyc < start + 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, cyc, lat);
  endtask

  // Leaves the caller #1 after edge E0 with soc already dropped.
  task automatic start_conv(input bit sel, input logic [NB-1:0] exp);
    @(posedge clk); #1;
    if (sel) exp_b_q.push_back(exp);
    else exp_a_q.push_back(exp);
    set_soc(sel, 1'b1);
    @(posedge clk); #1;
    set_soc(sel, 1'b0);
  endtask

  task automatic convert(input bit sel, input longint vin, input logic [NB-1:0] exp,
                         input int lat);
    if (sel) vin_b = vin;
    else vin_a = vin;
    start_conv(sel, exp);
    check("sample_rise", sel ? b_if.sample : a_if.sample, 1);
    check("busy_rise", sel ? b_if.busy : a_if.busy, 1);
    check("dac_clear", sel ? b_if.dac_code : a_if.dac_code, 0);
    wait_eoc(sel, 0, lat, "eoc_latency");
    check("dac_final", sel ? b_if.dac_code : a_if.dac_code, exp);
    check("busy_at_eoc", sel ? b_if.busy : a_if.busy, 0);
    @(posedge clk); #1;
    check("eoc_one_cycle", get_eoc(sel), 0);
    @(negedge clk);
  endtask

  initial begin
    a_if.soc = 1'b0;
    b_if.soc = 1'b0;
    vecs[0] = '{64'd1650000, 12'h800};
    vecs[1] = '{64'd0,       12'h000};
    vecs[2] = '{64'd3300000, 12'hFFF};
    vecs[3] = '{64'd1000000, 12'h4D9};
    vecs[4] = '{64'd500000,  12'h26C};
    vecs[5] = '{64'd3000000, 12'hE8B};

    #2;
    check("reset_outs_a", {a_if.sample, a_if.busy, a_if.eoc, a_if.ovr, a_if.dac_code,
                           a_if.data_out}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T1-T4 plus extra levels
    for (int i = 0; i < 6; i++) convert(1'b0, vecs[i].vin_uv, vecs[i].exp, 28);

    // T5: soc while busy
    vin_a = 64'd1650000;
    start_conv(1'b0, 12'h800);
    repeat (9) @(posedge clk);
    #1 a_if.soc = 1'b1;
    @(posedge clk); #1;
    a_if.soc = 1'b0;
    check("ovr_pulse", a_if.ovr, 1);
    @(posedge clk); #1;
    check("ovr_drop", a_if.ovr, 0);
    wait_eoc(1'b0, 11, 28, "eoc_latency_ovr");
    repeat (40) @(posedge clk);

    // T6: reset mid-conversion
    vin_a = 64'd1650000;
    @(posedge clk); #1 a_if.soc = 1'b1;
    @(posedge clk); #1 a_if.soc = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_abort_outs", {a_if.sample, a_if.busy, a_if.eoc, a_if.ovr, a_if.dac_code,
                               a_if.data_out}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    convert(1'b0, 64'd1000000, 12'h4D9, 28);

    // T7: back-to-back soc in DONE
    vin_a = 64'd1000000;
    start_conv(1'b0, 12'h4D9);
    wait_eoc(1'b0, 0, 28, "eoc_latency_first");
    vin_a = 64'd3300000;
    exp_a_q.push_back(12'hFFF);
    a_if.soc = 1'b1;
    @(posedge clk); #1;
    a_if.soc = 1'b0;
    check("b2b_sample", a_if.sample, 1);
    check("b2b_eoc_low", a_if.eoc, 0);
    check("b2b_hold_data", a_if.data_out, 12'h4D9);
    repeat (14) @(posedge clk);
    #1 check("b2b_mid_data", a_if.data_out, 12'h4D9);
    wait_eoc(1'b0, 14, 28, "eoc_latency_second");
    repeat (5) @(negedge clk);

    // T8: alternate timing parameters
    convert(1'b1, 64'd1000000, 12'h4D9, 50);
    convert(1'b1, 64'd3300000, 12'hFFF, 50);

    repeat (5) @(negedge clk);
    check("ovr_count_a", ovr_cnt_a, 1);
    check("ovr_count_b", ovr_cnt_b, 0);
    check("pending_a", exp_a_q.size(), 0);
    check("pending_b", exp_b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
